// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV32M multiply/divide unit. Shift-add multiply and
//            restoring divide on operand magnitudes, one bit per cycle, with
//            sign correction and high/low product selection in a final
//            fix-up cycle. Divide-by-zero and signed overflow finish in one
//            cycle.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int RADR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        func3,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [RADR_W-1:0] rd_adr,
  input  logic              flush,
  output logic              ready,
  output logic              stall,
  output logic              done,
  output logic [XLEN-1:0]   result,
  output logic [RADR_W-1:0] done_rd_adr
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] C_LAST = CW'(XLEN - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] F_MUL  = 3'd0;
  localparam logic [2:0] F_DIV  = 3'd4;
  localparam logic [2:0] F_REM  = 3'd6;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        op_q;
  logic [RADR_W-1:0] rd_q;
  logic              neg_q;
  logic [XLEN-1:0]   b_q;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;
  logic [XLEN-1:0]   result_q;
  logic [RADR_W-1:0] done_rd_q;

  // Operand decode at accept: signedness, magnitudes and bypass cases
  logic              w_a_neg, w_b_neg, w_neg;
  logic [XLEN-1:0]   w_mag_a, w_mag_b;
  logic              w_div_zero, w_ovf, w_bypass, w_accept;
  logic [XLEN-1:0]   w_byp_val;

  assign w_a_neg = rs1_data[XLEN-1] &
                   ((func3 == 3'd1) || (func3 == 3'd2) || (func3 == F_DIV) || (func3 == F_REM));
  assign w_b_neg = rs2_data[XLEN-1] &
                   ((func3 == 3'd1) || (func3 == F_DIV) || (func3 == F_REM));
  // REM takes the dividend's sign; everything else the sign of the product/quotient
  assign w_neg   = (func3 == F_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
  assign w_mag_a = w_a_neg ? (~rs1_data + 1'b1) : rs1_data;
  assign w_mag_b = w_b_neg ? (~rs2_data + 1'b1) : rs2_data;

  assign w_div_zero = func3[2] && (rs2_data == '0);
  assign w_ovf      = ((func3 == F_DIV) || (func3 == F_REM)) &&
                      (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2_data);
  assign w_bypass   = w_div_zero || w_ovf;
  // func3[1] distinguishes remainder ops from quotient ops
  assign w_byp_val  = w_div_zero ? (func3[1] ? rs1_data : {XLEN{1'b1}})
                                 : (func3[1] ? '0 : rs1_data);
  assign w_accept   = ready && start && !flush;

  // One iteration step of each algorithm
  logic [XLEN:0]     w_sum, w_shift, w_diff;
  assign w_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  assign w_shift = {hi_q, lo_q[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, b_q};

  // Fix-up: sign correction and half selection
  logic [2*XLEN-1:0] w_prod, w_prod_fix;
  logic [XLEN-1:0]   w_quo, w_rem, w_fix;
  assign w_prod     = {hi_q, lo_q};
  assign w_prod_fix = neg_q ? (~w_prod + 1'b1) : w_prod;
  assign w_quo      = neg_q ? (~lo_q + 1'b1) : lo_q;
  assign w_rem      = neg_q ? (~hi_q + 1'b1) : hi_q;
  assign w_fix      = op_q[2] ? (op_q[1] ? w_rem : w_quo)
                              : ((op_q == F_MUL) ? w_prod_fix[XLEN-1:0]
                                                 : w_prod_fix[2*XLEN-1:XLEN]);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; flush overrides everything but reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = w_bypass ? S_DONE : S_CALC;
        else       state_d = S_IDLE;
      end
      S_CALC:  if (cnt_q == C_LAST) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Handshake outputs decoded from state
  always_comb begin
    ready = (state_q == S_IDLE) || (state_q == S_DONE);
    done  = (state_q == S_DONE);
    stall = ((state_q == S_IDLE) && start) || (state_q == S_CALC) || (state_q == S_FIX);
  end

  // Datapath: capture, iterate, fix-up; flushed cycles leave it untouched
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      neg_q     <= 1'b0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      result_q  <= '0;
      done_rd_q <= '0;
    end else if (!flush) begin
      if (w_accept) begin
        op_q  <= func3;
        rd_q  <= rd_adr;
        neg_q <= w_neg;
        b_q   <= w_mag_b;
        hi_q  <= '0;
        lo_q  <= w_mag_a;
        cnt_q <= '0;
        if (w_bypass) begin
          result_q  <= w_byp_val;
          done_rd_q <= rd_adr;
        end
      end else if (state_q == S_CALC) begin
        cnt_q <= cnt_q + 1'b1;
        if (op_q[2]) begin
          if (!w_diff[XLEN]) begin
            hi_q <= w_diff[XLEN-1:0];
            lo_q <= {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_q <= w_shift[XLEN-1:0];
            lo_q <= {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          hi_q <= w_sum[XLEN:1];
          lo_q <= {w_sum[0], lo_q[XLEN-1:1]};
        end
      end else if (state_q == S_FIX) begin
        result_q  <= w_fix;
        done_rd_q <= rd_q;
      end
    end
  end

  assign result      = result_q;
  assign done_rd_adr = done_rd_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Directed self-checking bench for muldiv_unit (XLEN=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  func3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_adr;
  logic        flush;
  logic        ready;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic [4:0]  done_rd_adr;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(32), .RADR_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .func3       (func3),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .rd_adr      (rd_adr),
    .flush       (flush),
    .ready       (ready),
    .stall       (stall),
    .done        (done),
    .result      (result),
    .done_rd_adr (done_rd_adr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation and wait (bounded) for done; lat counts cycles after accept
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res,
                        output logic [4:0] tag, output int lat);
    @(posedge clk); #1;
    func3 = f; rs1_data = a; rs2_data = b; rd_adr = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 100);
    res = result;
    tag = done_rd_adr;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0; func3 = '0;
    rs1_data = '0; rs2_data = '0; rd_adr = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || stall !== 1'b0 || done !== 1'b0 || result !== 32'h0 || done_rd_adr !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: ready=%b stall=%b done=%b result=%h tag=%0d, required 1 0 0 0 0",
               ready, stall, done, result, done_rd_adr);
    end
  endtask

  task automatic test_mul();
    int done_at, stall_cnt, pulses;
    logic [31:0] r35;
    logic d35;
    done_at = 0; stall_cnt = 0; pulses = 0;
    @(posedge clk); #1;
    func3 = 3'd0; rs1_data = 32'd7; rs2_data = 32'hFFFF_FFFD; rd_adr = 5'd5; start = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL mul_stall_accept: stall=%b required 1", stall);
    end
    @(posedge clk); #1;
    start = 1'b0;
    r35 = '0; d35 = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (stall) stall_cnt++;
      if (done) begin
        pulses++;
        if (done_at == 0) done_at = c;
      end
      if (c == 35) begin r35 = result; d35 = done; end
    end
    checks++;
    if (done_at != 34 || pulses != 1) begin
      errors++;
      $display("FAIL mul_latency: done at %0d (%0d pulses), required 34 (1 pulse)", done_at, pulses);
    end
    checks++;
    if (stall_cnt != 33) begin
      errors++;
      $display("FAIL mul_stall_cycles: %0d, required 33", stall_cnt);
    end
    checks++;
    if (r35 !== 32'hFFFF_FFEB || done_rd_adr !== 5'd5 || d35 !== 1'b0) begin
      errors++;
      $display("FAIL mul_result: result=%h tag=%0d done=%b, required ffffffeb 5 0", r35, done_rd_adr, d35);
    end
  endtask

  task automatic test_mulh();
    logic [31:0] res; logic [4:0] tag; int lat;
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, res, tag, lat);
    checks++;
    if (res !== 32'hFFFF_FFFE || tag !== 5'd7 || lat != 34) begin
      errors++;
      $display("FAIL mulhu: result=%h tag=%0d lat=%0d, required fffffffe 7 34", res, tag, lat);
    end
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, res, tag, lat);
    checks++;
    if (res !== 32'h0000_0000 || tag !== 5'd8) begin
      errors++;
      $display("FAIL mulh: result=%h tag=%0d, required 00000000 8", res, tag);
    end
    // MULHSU: -1 (signed) * 0xFFFFFFFF (unsigned) = -(2^32-1); high word 0xFFFFFFFF
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, res, tag, lat);
    checks++;
    if (res !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL mulhsu: result=%h, required ffffffff", res);
    end
  endtask

  task automatic test_div();
    logic [31:0] res; logic [4:0] tag; int lat;
    run_op(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd10, res, tag, lat);
    checks++;
    if (res !== 32'hFFFF_FFFA || tag !== 5'd10 || lat != 34) begin
      errors++;
      $display("FAIL div: result=%h tag=%0d lat=%0d, required fffffffa 10 34", res, tag, lat);
    end
    run_op(3'd6, 32'hFFFF_FFEC, 32'd3, 5'd11, res, tag, lat);
    checks++;
    if (res !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL rem: result=%h, required fffffffe", res);
    end
    run_op(3'd5, 32'd20, 32'd3, 5'd12, res, tag, lat);
    checks++;
    if (res !== 32'd6) begin
      errors++;
      $display("FAIL divu: result=%h, required 00000006", res);
    end
    run_op(3'd7, 32'd20, 32'd3, 5'd13, res, tag, lat);
    checks++;
    if (res !== 32'd2) begin
      errors++;
      $display("FAIL remu: result=%h, required 00000002", res);
    end
  endtask

  task automatic test_div_special();
    logic [31:0] res; logic [4:0] tag; int lat;
    run_op(3'd5, 32'h0000_1234, 32'd0, 5'd14, res, tag, lat);
    checks++;
    if (res !== 32'hFFFF_FFFF || tag !== 5'd14 || lat != 1) begin
      errors++;
      $display("FAIL divu_by_zero: result=%h tag=%0d lat=%0d, required ffffffff 14 1", res, tag, lat);
    end
    run_op(3'd7, 32'h0000_1234, 32'd0, 5'd15, res, tag, lat);
    checks++;
    if (res !== 32'h0000_1234 || lat != 1) begin
      errors++;
      $display("FAIL remu_by_zero: result=%h lat=%0d, required 00001234 1", res, lat);
    end
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, res, tag, lat);
    checks++;
    if (res !== 32'h8000_0000 || tag !== 5'd16 || lat != 1) begin
      errors++;
      $display("FAIL div_overflow: result=%h tag=%0d lat=%0d, required 80000000 16 1", res, tag, lat);
    end
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, res, tag, lat);
    checks++;
    if (res !== 32'h0 || lat != 1) begin
      errors++;
      $display("FAIL rem_overflow: result=%h lat=%0d, required 00000000 1", res, lat);
    end
  endtask

  task automatic test_ignore_start();
    int done_at;
    logic [31:0] res;
    done_at = 0; res = '0;
    @(posedge clk); #1;
    func3 = 3'd0; rs1_data = 32'd9; rs2_data = 32'd9; rd_adr = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 5) begin
        func3 = 3'd5; rs1_data = 32'd100; rs2_data = 32'd0; rd_adr = 5'd30; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done && done_at == 0) begin done_at = c; res = result; end
      @(posedge clk); #1;
    end
    checks++;
    if (done_at != 34 || res !== 32'd81 || done_rd_adr !== 5'd3) begin
      errors++;
      $display("FAIL ignore_start: done at %0d result=%h tag=%0d, required 34 00000051 3",
               done_at, res, done_rd_adr);
    end
  endtask

  task automatic test_flush();
    logic [31:0] res; logic [4:0] tag; int lat, pulses;
    pulses = 0;
    @(posedge clk); #1;
    func3 = 3'd0; rs1_data = 32'd5; rs2_data = 32'd6; rd_adr = 5'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || stall !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: ready=%b stall=%b done=%b, required 1 0 0", ready, stall, done);
    end
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL flush_no_done: %0d pulses, required 0", pulses);
    end
    run_op(3'd0, 32'd3, 32'd4, 5'd21, res, tag, lat);
    checks++;
    if (res !== 32'd12 || tag !== 5'd21 || lat != 34) begin
      errors++;
      $display("FAIL flush_recover: result=%h tag=%0d lat=%0d, required 0000000c 21 34", res, tag, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat, pulses;
    @(posedge clk); #1;
    func3 = 3'd0; rs1_data = 32'd2; rs2_data = 32'd3; rd_adr = 5'd1; start = 1'b1;
    @(posedge clk); #1;
    func3 = 3'd5; rs1_data = 32'd100; rs2_data = 32'd7; rd_adr = 5'd2;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 100);
    checks++;
    if (result !== 32'd6 || done_rd_adr !== 5'd1 || lat != 34) begin
      errors++;
      $display("FAIL b2b_first: result=%h tag=%0d lat=%0d, required 00000006 1 34", result, done_rd_adr, lat);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b0 || stall !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_gap: ready=%b stall=%b done=%b, required 0 1 0", ready, stall, done);
    end
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (result !== 32'd14 || done_rd_adr !== 5'd2 || lat != 34) begin
      errors++;
      $display("FAIL b2b_second: result=%h tag=%0d lat=%0d, required 0000000e 2 34", result, done_rd_adr, lat);
    end
    // Reset pulse in the middle of a computation
    @(posedge clk); #1;
    func3 = 3'd4; rs1_data = 32'd50; rs2_data = 32'd5; rd_adr = 5'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || stall !== 1'b0 || done !== 1'b0 || result !== 32'h0 || done_rd_adr !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid_calc: ready=%b stall=%b done=%b result=%h tag=%0d, required 1 0 0 0 0",
               ready, stall, done, result, done_rd_adr);
    end
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_no_done: %0d pulses, required 0", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_div_special();
    test_ignore_start();
    test_flush();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
